// File: rtl/kernel_b_in_fifo_pkg.sv
// Shared defaults, transfer struct and sizing helper for the kernel_B input FIFO.
package kernel_b_in_fifo_pkg;

   localparam int KB_STREAMW  = 32;
   localparam int KB_DEPTH    = 16;
   localparam int KB_AFULL_TH = 12;
   localparam int KB_STAT_W   = 32;

   typedef struct packed {
      logic wr;
      logic rd;
   } kb_xfer_t;

   function automatic int kb_clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/kernel_b_in_fifo_sat_counter.sv
// Saturating event counter; clr has priority over inc and holds at all-ones once reached.
// Only built with STREAM_FIFO_STATS_EN, the sole user of this block.
`ifdef STREAM_FIFO_STATS_EN
module kernel_b_in_fifo_sat_counter #(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (inc && (value_q != '1)) value_d = value_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) value_q <= '0;
      else     value_q <= value_d;
   end

   assign value = value_q;

endmodule
`endif

// File: rtl/kernel_b_in_fifo.sv
// Elastic FWFT FIFO in front of kernel_B: a word written into an empty FIFO is visible next cycle; iready is
// registered and drops only when full, never from oready. STREAM_FIFO_STATS_EN adds stat_words/stat_stalls.
module kernel_b_in_fifo
   import kernel_b_in_fifo_pkg::*;
#(
   parameter int  STREAMW  = KB_STREAMW,
   parameter int  DEPTH    = KB_DEPTH,
   parameter int  AFULL_TH = KB_AFULL_TH,
   localparam int AW       = kb_clog2(DEPTH)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               ivalid,
   output logic               iready,
   input  logic [STREAMW-1:0] in1_s0,
   output logic               ovalid,
   input  logic               oready,
   output logic [STREAMW-1:0] out1_s0,
   output logic [AW:0]        fill_count,
   output logic               almost_full
`ifdef STREAM_FIFO_STATS_EN
  ,output logic [31:0]        stat_words,
   output logic [31:0]        stat_stalls
`endif
);

   logic [STREAMW-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]        fill_q, fill_d;
   logic               iready_q, iready_d;
   logic               afull_q, afull_d;
   kb_xfer_t           xfer;

   assign iready      = iready_q;
   assign ovalid      = (fill_q != '0);
   assign out1_s0     = mem[rd_ptr_q];
   assign fill_count  = fill_q;
   assign almost_full = afull_q;

   always_comb begin
      xfer.wr  = ivalid & iready_q;
      xfer.rd  = ovalid & oready;
      wr_ptr_d = xfer.wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = xfer.rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      fill_d   = fill_q;
      case (xfer)
         2'b10:   fill_d = fill_q + (AW+1)'(1);
         2'b01:   fill_d = fill_q - (AW+1)'(1);
         default: ;
      endcase
      // Ready and almost_full look at next-state occupancy so they are exact the cycle they are seen
      iready_d = (fill_d != (AW+1)'(DEPTH));
      afull_d  = (fill_d >= (AW+1)'(AFULL_TH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         iready_q <= 1'b0;
         afull_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         iready_q <= iready_d;
         afull_q  <= afull_d;
      end
   end

   always_ff @(posedge clk) begin
      if (xfer.wr && !rst) mem[wr_ptr_q] <= in1_s0;
   end

`ifdef STREAM_FIFO_STATS_EN
   kernel_b_in_fifo_sat_counter #(.WIDTH(KB_STAT_W)) u_stat_words (
      .clk   (clk),
      .clr   (rst),
      .inc   (xfer.wr),
      .value (stat_words)
   );

   kernel_b_in_fifo_sat_counter #(.WIDTH(KB_STAT_W)) u_stat_stalls (
      .clk   (clk),
      .clr   (rst),
      .inc   (ivalid & ~iready_q),
      .value (stat_stalls)
   );
`endif

endmodule

// File: tb/tb_kernel_b_in_fifo.sv
// Directed bench for kernel_b_in_fifo: reset, fill, drain, streaming, random scoreboard and mid-stream reset.
module tb_kernel_b_in_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        ivalid;
   logic        iready;
   logic [31:0] in1_s0;
   logic        ovalid;
   logic        oready;
   logic [31:0] out1_s0;
   logic [4:0]  fill_count;
   logic        almost_full;
`ifdef STREAM_FIFO_STATS_EN
   logic [31:0] stat_words;
   logic [31:0] stat_stalls;
`endif

   int errors = 0;
   int checks = 0;

   kernel_b_in_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .ivalid      (ivalid),
      .iready      (iready),
      .in1_s0      (in1_s0),
      .ovalid      (ovalid),
      .oready      (oready),
      .out1_s0     (out1_s0),
      .fill_count  (fill_count),
      .almost_full (almost_full)
`ifdef STREAM_FIFO_STATS_EN
     ,.stat_words  (stat_words),
      .stat_stalls (stat_stalls)
`endif
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] sb[$];
   logic [31:0] pend_dat;
   logic        pend;
   int          sent, popped, cyc;

   initial begin
      rst = 1'b1; ivalid = 1'b1; in1_s0 = 32'h55; oready = 1'b0;

      // Reset held 3 cycles with the producer offering a word
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_iready", iready, 0);
         chk("rst_ovalid", ovalid, 0);
         chk("rst_fill", fill_count, 0);
         chk("rst_afull", almost_full, 0);
      end
      rst = 1'b0; ivalid = 1'b0;
      chk("post_rst_iready", iready, 0);
      chk("post_rst_ovalid", ovalid, 0);
`ifdef STREAM_FIFO_STATS_EN
      chk("rst_stat_words", stat_words, 0);
      chk("rst_stat_stalls", stat_stalls, 0);
`endif
      step();
      chk("ready_after_rst", iready, 1);
      chk("fill_after_rst", fill_count, 0);

      // Fill with 0x1..0x10, no consumer
      for (int i = 1; i <= 16; i++) begin
         ivalid = 1'b1; in1_s0 = 32'(i);
         chk("fill_iready", iready, 1);
         step();
         chk("fill_count", fill_count, 64'(i));
         chk("fill_afull", almost_full, (i >= 12) ? 64'd1 : 64'd0);
      end
      chk("full_iready", iready, 0);
      in1_s0 = 32'h11;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("full_hold_fill", fill_count, 16);
         chk("full_hold_iready", iready, 0);
      end
`ifdef STREAM_FIFO_STATS_EN
      chk("fill_stat_words", stat_words, 16);
      chk("fill_stat_stalls", stat_stalls, 3);
`endif
      ivalid = 1'b0;

      // Drain in order, one word per cycle
      oready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         chk("drain_ovalid", ovalid, 1);
         chk("drain_data", out1_s0, 64'(k));
         step();
      end
      chk("drain_empty_ovalid", ovalid, 0);
      chk("drain_empty_fill", fill_count, 0);
      chk("drain_empty_afull", almost_full, 0);
      chk("drain_iready", iready, 1);

      // Continuous streaming of 0..99
      for (int c = 0; c <= 100; c++) begin
         ivalid = (c < 100);
         in1_s0 = 32'(c);
         if (c == 0) begin
            chk("stream_first_ovalid", ovalid, 0);
         end else begin
            chk("stream_ovalid", ovalid, 1);
            chk("stream_data", out1_s0, 64'(c - 1));
            chk("stream_fill", fill_count, 1);
            chk("stream_iready", iready, 1);
         end
         step();
      end
      ivalid = 1'b0;
      chk("stream_end_fill", fill_count, 0);

      // Random traffic against a queue scoreboard
      sb.delete();
      pend = 1'b0; pend_dat = '0; sent = 0; popped = 0; cyc = 0;
      while (popped < 5000 && cyc < 40000) begin
         if (!pend && sent < 5000 && $urandom_range(1, 0) == 1) begin
            pend = 1'b1;
            pend_dat = $urandom;
         end
         ivalid = pend;
         in1_s0 = pend_dat;
         oready = ($urandom_range(1, 0) == 1);
         chk("rand_fill", fill_count, 64'(sb.size()));
         chk("rand_ovalid", ovalid, (sb.size() != 0) ? 64'd1 : 64'd0);
         chk("rand_iready", iready, (sb.size() != 16) ? 64'd1 : 64'd0);
         if (ovalid && oready && sb.size() != 0) begin
            chk("rand_data", out1_s0, sb.pop_front());
            popped++;
         end
         if (ivalid && iready) begin
            sb.push_back(pend_dat);
            pend = 1'b0;
            sent++;
         end
         step();
         cyc++;
      end
      chk("rand_all_read", popped, 5000);
      chk("rand_end_fill", fill_count, 0);
      ivalid = 1'b0; oready = 1'b0;

      // Reset with seven words in flight
      for (int i = 0; i < 7; i++) begin
         ivalid = 1'b1; in1_s0 = 32'h70 + 32'(i);
         step();
      end
      ivalid = 1'b0;
      chk("mid_pre_fill", fill_count, 7);
      rst = 1'b1;
      step();
      chk("mid_rst_fill", fill_count, 0);
      chk("mid_rst_ovalid", ovalid, 0);
      chk("mid_rst_iready", iready, 0);
`ifdef STREAM_FIFO_STATS_EN
      chk("mid_stat_words", stat_words, 0);
      chk("mid_stat_stalls", stat_stalls, 0);
`endif
      rst = 1'b0;
      step();
      ivalid = 1'b1; in1_s0 = 32'hAA;
      step();
      ivalid = 1'b0;
      chk("mid_aa_ovalid", ovalid, 1);
      chk("mid_aa_data", out1_s0, 32'hAA);
      chk("mid_aa_fill", fill_count, 1);
      oready = 1'b1;
      step();
      chk("mid_aa_gone", ovalid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
